// File: rtl/sng_stream_pkg.sv
// Shared stochastic-computing definitions: stream FSM encoding and the
// default widths of the probability word and of the stream-length fields.
package sng_stream_pkg;

  localparam int SNG_P_W_DEFAULT   = 16;
  localparam int SNG_LEN_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sng_state_e;

endpackage

// File: rtl/sng_stream.sv
// Stochastic number generator: turns a probability word into a stream of
// len_in bits, each one being (random slice < probability). The stream is
// flow-controlled with a valid/ready pair, and a running count of emitted
// ones is kept. The random word is supplied by the parent through r.
module sng_stream
  import sng_stream_pkg::*;
#(
  parameter int P_W   = SNG_P_W_DEFAULT,
  parameter int LEN_W = SNG_LEN_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [63:0]      r,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [P_W-1:0]   p_in,
  input  logic [LEN_W-1:0] len_in,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic [LEN_W-1:0] ones_count,
  output logic             done
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [P_W-1:0]   P_ZERO   = {P_W{1'b0}};

  sng_state_e       state_r,     state_s;
  logic [P_W-1:0]   p_reg_r,     p_reg_s;
  logic [LEN_W-1:0] remain_r,    remain_s;
  logic [LEN_W-1:0] ones_r,      ones_s;
  logic             bit_out_r,   bit_out_s;
  logic             bit_valid_r, bit_valid_s;
  logic             done_r,      done_s;
  logic             p_ready_r,   p_ready_s;
  logic             new_bit_s;
  logic             slot_free_s;

  // Only the low P_W bits of the random word take part in the comparison.
  generate
    if (P_W < 64) begin : g_unused_r
      logic unused_r_s;
      assign unused_r_s = ^r[63:P_W];
    end
  endgenerate

  assign new_bit_s   = (r[P_W-1:0] < p_reg_r);
  // The output slot can take a new bit when it is empty or being consumed.
  assign slot_free_s = (~bit_valid_r) | bit_ready;

  // Next-state and next-output computation for the stream FSM.
  always_comb begin
    state_s     = state_r;
    p_reg_s     = p_reg_r;
    remain_s    = remain_r;
    ones_s      = ones_r;
    bit_out_s   = bit_out_r;
    bit_valid_s = bit_valid_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (p_valid) begin
          p_reg_s  = p_in;
          remain_s = len_in;
          ones_s   = LEN_ZERO;
          if (len_in != LEN_ZERO) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (remain_r != LEN_ZERO) begin
          if (slot_free_s) begin
            bit_out_s   = new_bit_s;
            bit_valid_s = 1'b1;
            remain_s    = remain_r - LEN_ONE;
            ones_s      = ones_r + {{(LEN_W-1){1'b0}}, new_bit_s};
          end else begin
            bit_valid_s = bit_valid_r;
          end
        end else begin
          // Last bit is leaving (or none pending): finish the stream.
          if (slot_free_s) begin
            bit_valid_s = 1'b0;
            state_s     = ST_DONE;
            done_s      = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s     = ST_IDLE;
        bit_valid_s = 1'b0;
      end
    endcase
    p_ready_s = (state_s == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r     <= ST_IDLE;
      p_reg_r     <= P_ZERO;
      remain_r    <= LEN_ZERO;
      ones_r      <= LEN_ZERO;
      bit_out_r   <= 1'b0;
      bit_valid_r <= 1'b0;
      done_r      <= 1'b0;
      p_ready_r   <= 1'b1;
    end else begin
      state_r     <= state_s;
      p_reg_r     <= p_reg_s;
      remain_r    <= remain_s;
      ones_r      <= ones_s;
      bit_out_r   <= bit_out_s;
      bit_valid_r <= bit_valid_s;
      done_r      <= done_s;
      p_ready_r   <= p_ready_s;
    end
  end

  assign p_ready    = p_ready_r;
  assign bit_out    = bit_out_r;
  assign bit_valid  = bit_valid_r;
  assign ones_count = ones_r;
  assign done       = done_r;

endmodule
